alu_pipe: RTL and testbench

Parametrised, two-stage pipelined ALU with valid/ready handshakes on both sides. It is the next-generation replacement for the 8-bit single-register ALU in the VeriRISC datapath. It keeps the same `opcode_t` operation set (ADD/AND/XOR/LDA plus pass-through of `accum` for HLT/SKZ/STO/JMP) and the operand-zero flag. It adds:
- configurable width;
- backpressure;
- a carry flag;
- a result-zero flag;
- a tag passed through in order.

---
 rtl/alu_pipe.sv | 124 ++++++++++++
 tb/tb_alu_pipe.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage pipelined ALU with valid/ready handshakes; optional ADD saturation via ALU_SAT_EN
package alu_pipe_pkg;
  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;
endpackage

module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  opcode_t          opcode,
  input  logic [WIDTH-1:0] accum,
  input  logic [WIDTH-1:0] data,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             res_zero,
  output logic             carry,
  output logic [TAG_W-1:0] tag_out
);

  // Stage A: operand register
  logic             a_v;
  opcode_t          a_op;
  logic [WIDTH-1:0] a_accum;
  logic [WIDTH-1:0] a_data;
  logic [TAG_W-1:0] a_tag;

  // Handshake / advance controls
  logic adv_a;
  logic adv_b;

  // Combinational result computed from stage A
  logic [WIDTH:0]   sum_full;
  logic [WIDTH-1:0] res;
  logic             res_carry;

  // Stage B may load whenever it is empty or its result is being taken;
  // stage A may load whenever it is empty or it can hand off to stage B.
  always_comb begin
    adv_b    = !out_valid || out_ready;
    adv_a    = !a_v || adv_b;
    in_ready = adv_a;
  end

  // Operation decode on the stage A operands
  always_comb begin
    sum_full  = {1'b0, a_accum} + {1'b0, a_data};
    res       = a_accum;
    res_carry = 1'b0;
    case (a_op)
      ADD: begin
        res       = sum_full[WIDTH-1:0];
        res_carry = sum_full[WIDTH];
`ifdef ALU_SAT_EN
        if (sum_full[WIDTH]) begin
          res = '1;
        end
`endif
      end
      AND:     res = a_accum & a_data;
      XOR:     res = a_accum ^ a_data;
      LDA:     res = a_data;
      default: res = a_accum;
    endcase
  end

  // Stage A register: captures a new operation whenever it advances
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_v     <= 1'b0;
      a_op    <= HLT;
      a_accum <= '0;
      a_data  <= '0;
      a_tag   <= '0;
    end else if (adv_a) begin
      a_v <= in_valid;
      if (in_valid) begin
        a_op    <= opcode;
        a_accum <= accum;
        a_data  <= data;
        a_tag   <= tag_in;
      end
    end
  end

  // Stage B register: result and flags, held while downstream stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= '0;
      zero      <= 1'b0;
      res_zero  <= 1'b0;
      carry     <= 1'b0;
      tag_out   <= '0;
    end else if (adv_b) begin
      out_valid <= a_v;
      if (a_v) begin
        out      <= res;
        zero     <= (a_accum == '0);
        res_zero <= (res == '0);
        carry    <= res_carry;
        tag_out  <= a_tag;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - scoreboard testbench for alu_pipe (WIDTH=8, TAG_W=4)
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  typedef struct packed {
    logic [7:0] out;
    logic       zero;
    logic       res_zero;
    logic       carry;
    logic [3:0] tag;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  opcode_t    opcode;
  logic [7:0] accum;
  logic [7:0] data;
  logic [3:0] tag_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic       zero;
  logic       res_zero;
  logic       carry;
  logic [3:0] tag_out;

  int   n_cmp;
  int   n_fail;
  int   n_pop;
  bit   last_acc;
  bit   stall_prev;
  exp_t held;
  exp_t sb[$];

  alu_pipe #(.WIDTH(8), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .accum(accum), .data(data), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zero(zero), .res_zero(res_zero), .carry(carry), .tag_out(tag_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model of one operation
  function automatic exp_t model(input opcode_t op, input logic [7:0] a, input logic [7:0] d,
                                 input logic [3:0] t);
    exp_t e;
    int   s;
    s = int'(a) + int'(d);
    e.carry = 1'b0;
    case (op)
      ADD: begin
        e.out   = s[7:0];
        e.carry = (s > 255);
`ifdef ALU_SAT_EN
        if (s > 255) e.out = 8'hFF;
`endif
      end
      AND:     e.out = a & d;
      XOR:     e.out = a ^ d;
      LDA:     e.out = d;
      default: e.out = a;
    endcase
    e.zero     = (a == 8'h00);
    e.res_zero = (e.out == 8'h00);
    e.tag      = t;
    return e;
  endfunction

  task automatic set_in(input opcode_t op, input logic [7:0] a, input logic [7:0] d,
                        input logic [3:0] t);
    opcode = op;
    accum  = a;
    data   = d;
    tag_in = t;
  endtask

  // One clock: entered and left just after the falling edge.
  task automatic cycle();
    exp_t got;
    exp_t e;
    #1;
    got = {out, zero, res_zero, carry, tag_out};
    if (stall_prev) begin
      n_cmp++;
      if (out_valid !== 1'b1 || got !== held) begin
        n_fail++;
        $display("FAIL hold_stable: got valid=%b %h, required valid=1 %h", out_valid, got, held);
      end
    end
    stall_prev = out_valid && !out_ready;
    held       = got;
    last_acc   = in_valid && in_ready;
    if (last_acc) sb.push_back(model(opcode, accum, data, tag_in));
    if (out_valid && out_ready) begin
      n_cmp++;
      n_pop++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got %h, required no result", got);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL sb_result: got out=%h z=%b rz=%b c=%b tag=%h, required out=%h z=%b rz=%b c=%b tag=%h",
                   out, zero, res_zero, carry, tag_out, e.out, e.zero, e.res_zero, e.carry, e.tag);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input opcode_t op, input logic [7:0] a, input logic [7:0] d,
                       input logic [3:0] t);
    bit done;
    done = 0;
    set_in(op, a, d, t);
    in_valid = 1'b1;
    for (int i = 0; i < 10 && !done; i++) begin
      cycle();
      done = last_acc;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (!done) begin
      n_fail++;
      $display("FAIL issue_timeout: accepted=0, required 1");
    end
  endtask

  task automatic wait_out(output bit ok);
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      #1;
      if (out_valid) ok = 1;
      else cycle();
    end
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && (sb.size() != 0 || out_valid); i++) cycle();
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: pending=%0d, required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({out_valid, out, zero, res_zero, carry, tag_out} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b out=%h z=%b rz=%b c=%b tag=%h, required all 0",
               out_valid, out, zero, res_zero, carry, tag_out);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
    out_ready = 1'b0;
    set_in(ADD, 8'h03, 8'h04, 4'h5);
    in_valid = 1'b1;
    cycle();
    set_in(XOR, 8'h0F, 8'h01, 4'h9);
    cycle();
    in_valid = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b1 || out !== 8'h07 || tag_out !== 4'h5) begin
      n_fail++;
      $display("FAIL reset_fill: got v=%b out=%h tag=%h, required v=1 out=07 tag=5", out_valid, out, tag_out);
    end
    #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, out, zero, res_zero, carry, tag_out} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_async: got v=%b out=%h z=%b rz=%b c=%b tag=%h, required all 0",
               out_valid, out, zero, res_zero, carry, tag_out);
    end
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    stall_prev = 0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b, required 1", in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_stale: got out_valid=%b tag=%h, required 0", out_valid, tag_out);
      end
      cycle();
    end
  endtask

  task automatic test_stream();
    opcode_t    ops[6] = '{ADD, ADD, AND, XOR, LDA, STO};
    logic [7:0] as[6]  = '{8'h01, 8'h01, 8'h03, 8'h15, 8'h07, 8'h08};
    logic [7:0] ds[6]  = '{8'h01, 8'h02, 8'h02, 8'h03, 8'h0A, 8'h03};
    logic [7:0] xs[6]  = '{8'h02, 8'h03, 8'h02, 8'h16, 8'h0A, 8'h08};
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k < 6) begin
        set_in(ops[k], as[k], ds[k], 4'(k));
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      n_cmp++;
      if (k >= 2) begin
        if (out_valid !== 1'b1 || tag_out !== 4'(k - 2) || out !== xs[k-2]) begin
          n_fail++;
          $display("FAIL stream_%0d: got v=%b out=%h tag=%h, required v=1 out=%h tag=%h",
                   k, out_valid, out, tag_out, xs[k-2], 4'(k - 2));
        end
      end else if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stream_latency_%0d: got out_valid=%b, required 0", k, out_valid);
      end
      cycle();
    end
    drain();
  endtask

  task automatic test_zero_flags();
    opcode_t    ops[3] = '{STO, LDA, AND};
    logic [7:0] as[3]  = '{8'h00, 8'h00, 8'hF0};
    logic [7:0] ds[3]  = '{8'h0A, 8'h0A, 8'h0F};
    logic [7:0] xo[3]  = '{8'h00, 8'h0A, 8'h00};
    logic [2:0] xf[3]  = '{3'b110, 3'b100, 3'b010};
    bit ok;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], as[i], ds[i], 4'(i + 8));
      wait_out(ok);
      n_cmp++;
      if (!ok || out !== xo[i] || {zero, res_zero, carry} !== xf[i]) begin
        n_fail++;
        $display("FAIL zero_flags_%0d: got v=%b out=%h z/rz/c=%b, required out=%h z/rz/c=%b",
                 i, ok, out, {zero, res_zero, carry}, xo[i], xf[i]);
      end
      cycle();
    end
    drain();
  endtask

  task automatic test_carry();
    logic [7:0] as[2] = '{8'hFF, 8'h7F};
    logic [7:0] ds[2] = '{8'h02, 8'h01};
`ifdef ALU_SAT_EN
    logic [7:0] xo[2] = '{8'hFF, 8'h80};
`else
    logic [7:0] xo[2] = '{8'h01, 8'h80};
`endif
    logic       xc[2] = '{1'b1, 1'b0};
    bit ok;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      issue(ADD, as[i], ds[i], 4'(i + 3));
      wait_out(ok);
      n_cmp++;
      if (!ok || out !== xo[i] || carry !== xc[i] || res_zero !== 1'b0) begin
        n_fail++;
        $display("FAIL carry_%0d: got v=%b out=%h c=%b rz=%b, required out=%h c=%b rz=0",
                 i, ok, out, carry, res_zero, xo[i], xc[i]);
      end
      cycle();
    end
    drain();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) set_in(ADD, 8'h10, 8'h20, 4'h1);
      else        set_in(XOR, 8'h55, 8'hFF, 4'h2);
      in_valid = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_accept_%0d: got in_ready=%b, required 1", i, in_ready);
      end
      cycle();
    end
    set_in(AND, 8'hCC, 8'h0F, 4'h3);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out !== 8'h30 || tag_out !== 4'h1) begin
        n_fail++;
        $display("FAIL bp_stall_%0d: got in_ready=%b v=%b out=%h tag=%h, required 0 1 30 1",
                 i, in_ready, out_valid, out, tag_out);
      end
      cycle();
    end
    out_ready = 1'b1;
    cycle();
    n_cmp++;
    if (!last_acc) begin
      n_fail++;
      $display("FAIL bp_resume: accepted=0, required 1");
    end
    drain();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    set_in(ADD, 8'h01, 8'h05, 4'hA);
    in_valid = 1'b1;
    cycle();
    set_in(LDA, 8'h02, 8'h66, 4'hB);
    cycle();
    set_in(XOR, 8'h0F, 8'hF0, 4'hC);
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || tag_out !== 4'hA) begin
      n_fail++;
      $display("FAIL b2b_pre: got in_ready=%b v=%b tag=%h, required 1 1 A", in_ready, out_valid, tag_out);
    end
    cycle();
    n_cmp++;
    if (!last_acc) begin
      n_fail++;
      $display("FAIL b2b_accept: accepted=0, required 1");
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || tag_out !== 4'hB || out !== 8'h66) begin
      n_fail++;
      $display("FAIL b2b_full: got v=%b in_ready=%b tag=%h out=%h, required 1 0 B 66",
               out_valid, in_ready, tag_out, out);
    end
    drain();
  endtask

  task automatic test_random();
    int sent;
    int pop0;
    sent = 0;
    pop0 = n_pop;
    in_valid = 1'b0;
    for (int c = 0; c < 3000 && sent < 50; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (!in_valid) begin
        set_in(opcode_t'(3'($urandom_range(0, 7))), 8'($urandom_range(0, 255)),
               8'($urandom_range(0, 255)), 4'(sent));
        in_valid = 1'($urandom_range(0, 1));
      end
      cycle();
      if (last_acc) begin
        in_valid = 1'b0;
        sent++;
      end
    end
    drain();
    n_cmp++;
    if (sent != 50 || n_pop - pop0 != 50) begin
      n_fail++;
      $display("FAIL random_count: sent=%0d popped=%0d, required 50 50", sent, n_pop - pop0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp      = 0;
    n_fail     = 0;
    n_pop      = 0;
    stall_prev = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    set_in(HLT, 8'h00, 8'h00, 4'h0);
    @(negedge clk);
    test_reset();
    test_stream();
    test_zero_flags();
    test_carry();
    test_backpressure();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
